// File: rtl/banked_mem_responder.sv
// Interleaved multi-bank main-memory model answering cache mem_rd/mem_wr.
// Each access holds its bank for a fixed time; reads return in issue order.
module banked_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LOG2  = 10,
  parameter int NUM_BANKS = 4,
  parameter int BANK_BUSY = 4,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 stall,
  output logic                 err
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = (BANK_BUSY > 2) ? $clog2(BANK_BUSY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BANK_BUSY - 1);

  logic [DATA_W-1:0] mem [2**MEM_LOG2];
  logic [CW-1:0]     cnt [NUM_BANKS];
  logic [RD_LAT-1:0] pv;
  logic [DATA_W-1:0] pd  [RD_LAT];

  logic [BW-1:0]       bank;
  logic [MEM_LOG2-1:0] idx;
  logic                malformed;
  logic                req;
  logic                accept;
  logic                addr_unused;

  assign bank = addr[BW:1];
  assign idx  = addr[MEM_LOG2:1];
  assign addr_unused = ^addr[ADDR_W-1:MEM_LOG2+1];

  assign malformed = (wr & rd) | ((wr | rd) & addr[0]);
  assign req       = (wr | rd) & ~malformed;

  always_comb begin
    busy = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      busy[b] = (cnt[b] != '0);
    end
  end

  assign stall  = req & busy[bank];
  assign accept = req & ~busy[bank];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (accept && bank == BW'(b)) begin
          cnt[b] <= CNT_LOAD;
        end else if (cnt[b] != '0) begin
          cnt[b] <= cnt[b] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= malformed;
    end
  end

  // Array is deliberately not reset; writes are blocked while rst is held.
  always_ff @(posedge clk) begin
    if (accept && wr && !rst) begin
      mem[idx] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept & rd;
      pd[0] <= (accept && rd) ? mem[idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign data_valid = pv[RD_LAT-1];
  assign data_out   = pv[RD_LAT-1] ? pd[RD_LAT-1] : '0;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed scoreboard bench for banked_mem_responder.
// Read returns are checked for data, order and exact cycle.
module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  busy;
  logic        stall;
  logic        err;

  int cmp = 0;
  int mis = 0;
  int cyc_n = 0;

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];

  banked_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .wr         (wr),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .stall      (stall),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (data_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", {31'd0, data_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rd_data", {16'd0, data_out}, {16'd0, e.d});
        chk("rd_cycle", cyc_n, e.due);
      end
    end else begin
      chk("idle_data_out", {16'd0, data_out}, 32'd0);
      if (q.size() > 0 && q[0].due <= cyc_n) begin
        chk("missing_valid", {31'd0, data_valid}, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic cyc(input logic w, input logic r,
                     input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    wr = w;
    rd = r;
    addr = a;
    data_in = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Called mid-cycle of the accepting read.
  task automatic exp_rd(input logic [15:0] d);
    q.push_back('{cyc_n + 2, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    addr = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: write then immediate read of same bank stalls three cycles
    cyc(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    chk("t1_wr_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'h0010, 16'h0);
      chk("t1_rd_stall", {31'd0, stall}, 32'd1);
      if (i == 0) chk("t1_busy", {28'd0, busy}, 32'h1);
    end
    cyc(1'b0, 1'b1, 16'h0010, 16'h0);
    chk("t1_rd_accept", {31'd0, stall}, 32'd0);
    exp_rd(16'hBEEF);
    idle(4);

    // 2: back-to-back reads across all banks
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'(2 * i), 16'hA000 + 16'(i));
      chk("t2_wr_stall", {31'd0, stall}, 32'd0);
    end
    idle(4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 16'(2 * i), 16'h0);
      chk("t2_rd_stall", {31'd0, stall}, 32'd0);
      exp_rd(16'hA000 + 16'(i));
      if (i == 3) chk("t2_busy_n3", {28'd0, busy}, 32'h7);
    end
    idle(1);
    chk("t2_busy_n4", {28'd0, busy}, 32'hE);
    idle(4);

    // 3: malformed requests are ignored and flagged
    cyc(1'b1, 1'b0, 16'h0002, 16'h1111);
    idle(4);
    cyc(1'b1, 1'b1, 16'h0002, 16'h2222);
    chk("t3_bad_stall", {31'd0, stall}, 32'd0);
    chk("t3_err_pre", {31'd0, err}, 32'd0);
    idle(1);
    chk("t3_err_pulse", {31'd0, err}, 32'd1);
    chk("t3_busy", {28'd0, busy}, 32'd0);
    idle(1);
    chk("t3_err_clear", {31'd0, err}, 32'd0);
    cyc(1'b1, 1'b0, 16'h0003, 16'h3333);
    chk("t3_odd_stall", {31'd0, stall}, 32'd0);
    idle(1);
    chk("t3_odd_err", {31'd0, err}, 32'd1);
    chk("t3_odd_busy", {28'd0, busy}, 32'd0);
    idle(1);
    chk("t3_odd_clear", {31'd0, err}, 32'd0);
    cyc(1'b0, 1'b1, 16'h0002, 16'h0);
    chk("t3_rd_stall", {31'd0, stall}, 32'd0);
    exp_rd(16'h1111);
    idle(4);

    // 4: reset discards in-flight read
    cyc(1'b1, 1'b0, 16'h0008, 16'h4444);
    idle(4);
    cyc(1'b0, 1'b1, 16'h0008, 16'h0);
    chk("t4_rd_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd = 1'b0;
    @(negedge clk);
    chk("t4_rst_busy", {28'd0, busy}, 32'd0);
    chk("t4_rst_valid", {31'd0, data_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd = 1'b1;
    addr = 16'h0008;
    @(negedge clk);
    chk("t4_post_rst_accept", {31'd0, stall}, 32'd0);
    exp_rd(16'h4444);
    idle(4);

    // 5: held write to a busy bank lands exactly once
    cyc(1'b1, 1'b0, 16'h0028, 16'h5555);
    chk("t5_first_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 16'h0020, 16'h6660 + 16'(i));
      chk("t5_hold_stall", {31'd0, stall}, (i == 3) ? 32'd0 : 32'd1);
    end
    idle(4);
    cyc(1'b0, 1'b1, 16'h0020, 16'h0);
    exp_rd(16'h6663);
    idle(4);
    cyc(1'b0, 1'b1, 16'h0028, 16'h0);
    exp_rd(16'h5555);
    idle(4);

    // 6: outputs stay quiet under reset regardless of inputs
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      chk("t6_data_out", {16'd0, data_out}, 32'd0);
      chk("t6_valid", {31'd0, data_valid}, 32'd0);
      chk("t6_busy", {28'd0, busy}, 32'd0);
      chk("t6_err", {31'd0, err}, 32'd0);
      chk("t6_stall", {31'd0, stall}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    idle(2);
    cyc(1'b0, 1'b1, 16'h0004, 16'h0);
    chk("t6_rd_stall", {31'd0, stall}, 32'd0);
    exp_rd(16'hA002);
    idle(4);
    chk("drain", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
